bus_init_sequencer: RTL and testbench
=====================================

// Module: bus_init_sequencer
// PURPOSE
//  Hardware init sequencer for the VIC-II/RAM bus. Fill mode writes an incrementing pattern
//  into video RAM; table mode writes {reg,data} pairs from a table ROM into chip registers.
//  Generalised in widths, table depth, strobe hold time and mode. Drives the CPU-side
//  cs/we/addr/data ports while aec grants the bus; sits ahead of vicii at boot.
// PARAMETERS
//  ADDR_WIDTH   14  memory address width (mem_addr, fill_base, fill_len)
//  DATA_WIDTH   12  memory data width; must be >= 8
//  REG_AW        6  register address width
//  TABLE_DEPTH  64  max table entries; TAW = $clog2(TABLE_DEPTH)
//  HOLD_CYCLES   8  cycles each write strobe is held high; must be >= 1
// PORTS
//  clk        in   1                 system clock, all logic on rising edge
//  rst_n      in   1                 asynchronous reset, active low
//  start      in   1                 begin a sequence; sampled only in IDLE
//  abort      in   1                 synchronous abort; highest priority after rst_n
//  mode       in   2                 00 table, 01 fill, 10 fill then table, 11 = table
//  fill_base  in   ADDR_WIDTH        first fill address
//  fill_len   in   ADDR_WIDTH        number of fill writes; 0 = skip fill
//  fill_hi    in   DATA_WIDTH-8      constant upper data bits for fill words
//  tbl_len    in   TAW+1             number of table entries; 0 = skip table
//  tbl_addr   out  TAW               table ROM address
//  tbl_data   in   REG_AW+8          {reg_addr, reg_data}; valid 1 cycle after tbl_addr
//  mem_addr   out  ADDR_WIDTH        memory write address
//  mem_do     out  DATA_WIDTH        memory write data
//  mem_we     out  1                 memory write strobe
//  reg_addr   out  REG_AW            register address
//  reg_do     out  8                 register write data
//  reg_cs     out  1                 register chip select
//  reg_we     out  1                 register write enable (equals reg_cs)
//  busy       out  1                 high in every non-IDLE state
//  done       out  1                 one-cycle pulse when a sequence completes
// BEHAVIOUR
//  - All outputs registered; reset value of every output is 0; state = IDLE.
//  - States: IDLE, FILL, FGAP, TFETCH, TWRITE, TGAP, DONE.
//  - IDLE: start=1 latches mode, fill_*, tbl_len. Next state is FILL if mode=01/10 and
//    fill_len!=0; else TFETCH if tbl_len!=0; else DONE.
//  - FILL: mem_we=1 for exactly HOLD_CYCLES cycles; mem_addr = fill_base+k (mod 2^ADDR_WIDTH,
//    wraps); mem_do = {fill_hi, k[7:0]}; k counts 0..fill_len-1. addr/data stable during hold.
//  - FGAP: one cycle with mem_we=0. Then FILL with k+1, or after the last write go to table
//    (mode 10, tbl_len!=0) else DONE.
//  - TFETCH: drive tbl_addr=j for 1 cycle. TWRITE registers tbl_data: reg_addr=upper REG_AW
//    bits, reg_do=low 8 bits; reg_cs=reg_we=1 for HOLD_CYCLES cycles. TGAP: 1 cycle low.
//    Then TFETCH j+1, or DONE after entry tbl_len-1. tbl_len > TABLE_DEPTH is clamped.
//  - DONE: done=1, busy=0 for one cycle, then IDLE. Back-to-back start is accepted in the
//    IDLE cycle that follows.
//  - Latency: start sampled at edge E0 -> first strobe high after E1 (fill) or after E2 (table).
//    One write costs HOLD_CYCLES+1 cycles (fill) or HOLD_CYCLES+2 cycles (table).
//  - start while busy is ignored; inputs latched at start are immune to later changes.
//  - abort=1 in any state: all strobes low at the next edge, state IDLE, no done pulse.
//  - mem_we and reg_cs are never high in the same cycle.
//  - rst_n low mid-write: strobes drop immediately (async); the sequence is lost.
// TESTING
//  - mode=01, base=0, len=4, fill_hi=1, HOLD=8: writes 0x100..0x103 to addr 0..3, each
//    mem_we 8 cycles + 1 gap; done pulses 36 cycles after first strobe.
//  - mode=00, tbl_len=3, table {0x18:04,0x11:18,0x20:0c}: reg_cs windows of 8 cycles,
//    10 cycles apart, with matching reg_addr/reg_do; done once.
//  - mode=10, fill_len=2, tbl_len=1: two mem writes strictly precede one reg write; no overlap.
//  - base=0x3FFE, len=4: addresses 3FFE,3FFF,0000,0001 (wrap).
//  - abort on 3rd cycle of a table write: strobes low next edge, busy=0, done never pulses.
//    start during busy: no effect. fill_len=0 and tbl_len=0: done 1 cycle after start, no strobes.
//  - rst_n low mid-fill: all outputs 0 asynchronously. A new start after release runs cleanly.

Source files
------------

// File: rtl/bus_init_sequencer.sv
// Boot-time bus init sequencer: fills video RAM with an incrementing pattern and/or
// replays {reg,data} pairs from a table ROM into chip registers while the bus is granted.
module bus_init_sequencer #(
    parameter int unsigned ADDR_WIDTH  = 14,
    parameter int unsigned DATA_WIDTH  = 12,
    parameter int unsigned REG_AW      = 6,
    parameter int unsigned TABLE_DEPTH = 64,
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              abort,
    input  logic [1:0]                        mode,
    input  logic [ADDR_WIDTH-1:0]             fill_base,
    input  logic [ADDR_WIDTH-1:0]             fill_len,
    input  logic [DATA_WIDTH-9:0]             fill_hi,
    input  logic [$clog2(TABLE_DEPTH):0]      tbl_len,
    output logic [$clog2(TABLE_DEPTH)-1:0]    tbl_addr,
    input  logic [REG_AW+7:0]                 tbl_data,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_do,
    output logic                              mem_we,
    output logic [REG_AW-1:0]                 reg_addr,
    output logic [7:0]                        reg_do,
    output logic                              reg_cs,
    output logic                              reg_we,
    output logic                              busy,
    output logic                              done
);

    localparam int unsigned TAW = $clog2(TABLE_DEPTH);
    localparam int unsigned HCW = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned DHW = DATA_WIDTH - 8;
    localparam logic [TAW:0]     TBL_MAX   = (TAW+1)'(TABLE_DEPTH);
    localparam logic [HCW-1:0]   HOLD_LAST = HCW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_FGAP, S_TFETCH, S_TWRITE, S_TGAP, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   then_tbl_q, then_tbl_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [ADDR_WIDTH-1:0]  flen_q, flen_d;
    logic [ADDR_WIDTH-1:0]  k_q, k_d;
    logic [DHW-1:0]         fhi_q, fhi_d;
    logic [TAW:0]           tlen_q, tlen_d;
    logic [TAW:0]           j_q, j_d;
    logic [HCW-1:0]         hold_q, hold_d;

    logic [TAW-1:0]         tbl_addr_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_d;
    logic [DATA_WIDTH-1:0]  mem_do_d;
    logic                   mem_we_d;
    logic [REG_AW-1:0]      reg_addr_d;
    logic [7:0]             reg_do_d;
    logic                   reg_cs_d;
    logic                   busy_d;
    logic                   done_d;

    logic                   fill_sel;
    logic                   tbl_sel;
    logic                   hold_last;

    assign fill_sel  = (mode == 2'b01) || (mode == 2'b10);
    assign tbl_sel   = (mode != 2'b01);
    assign hold_last = (hold_q == HOLD_LAST);

    // Next-state and next-output decode; strobes trail the state by one register stage.
    always_comb begin
        state_d    = state_q;
        then_tbl_d = then_tbl_q;
        base_d     = base_q;
        flen_d     = flen_q;
        k_d        = k_q;
        fhi_d      = fhi_q;
        tlen_d     = tlen_q;
        j_d        = j_q;
        hold_d     = hold_q;
        tbl_addr_d = tbl_addr;
        mem_addr_d = mem_addr;
        mem_do_d   = mem_do;
        reg_addr_d = reg_addr;
        reg_do_d   = reg_do;
        mem_we_d   = (state_q == S_FILL);
        reg_cs_d   = (state_q == S_TWRITE);
        busy_d     = (state_q != S_IDLE) && (state_q != S_DONE);
        done_d     = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    then_tbl_d = (mode == 2'b10);
                    base_d     = fill_base;
                    flen_d     = fill_len;
                    fhi_d      = fill_hi;
                    tlen_d     = (tbl_len > TBL_MAX) ? TBL_MAX : tbl_len;
                    k_d        = '0;
                    j_d        = '0;
                    hold_d     = '0;
                    if (fill_sel && (fill_len != '0)) begin
                        state_d = S_FILL;
                    end else if (tbl_sel && (tbl_len != '0)) begin
                        state_d    = S_TFETCH;
                        tbl_addr_d = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FILL: begin
                mem_addr_d = base_q + k_q;
                mem_do_d   = {fhi_q, 8'(k_q)};
                if (hold_last) begin
                    hold_d  = '0;
                    state_d = S_FGAP;
                end else begin
                    hold_d = hold_q + HCW'(1);
                end
            end
            S_FGAP: begin
                if (k_q == flen_q - ADDR_WIDTH'(1)) begin
                    if (then_tbl_q && (tlen_q != '0)) begin
                        state_d    = S_TFETCH;
                        j_d        = '0;
                        tbl_addr_d = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    k_d     = k_q + ADDR_WIDTH'(1);
                    state_d = S_FILL;
                end
            end
            S_TFETCH: begin
                hold_d  = '0;
                state_d = S_TWRITE;
            end
            S_TWRITE: begin
                // ROM data for tbl_addr is valid on entry; capture it once per entry
                if (hold_q == '0) begin
                    reg_addr_d = tbl_data[REG_AW+7:8];
                    reg_do_d   = tbl_data[7:0];
                end
                if (hold_last) begin
                    hold_d  = '0;
                    state_d = S_TGAP;
                end else begin
                    hold_d = hold_q + HCW'(1);
                end
            end
            S_TGAP: begin
                if (j_q == tlen_q - (TAW+1)'(1)) begin
                    state_d = S_DONE;
                end else begin
                    j_d        = j_q + (TAW+1)'(1);
                    tbl_addr_d = TAW'(j_q + (TAW+1)'(1));
                    state_d    = S_TFETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d  = S_IDLE;
            mem_we_d = 1'b0;
            reg_cs_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            then_tbl_q <= 1'b0;
            base_q     <= '0;
            flen_q     <= '0;
            k_q        <= '0;
            fhi_q      <= '0;
            tlen_q     <= '0;
            j_q        <= '0;
            hold_q     <= '0;
            tbl_addr   <= '0;
            mem_addr   <= '0;
            mem_do     <= '0;
            mem_we     <= 1'b0;
            reg_addr   <= '0;
            reg_do     <= '0;
            reg_cs     <= 1'b0;
            reg_we     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            then_tbl_q <= then_tbl_d;
            base_q     <= base_d;
            flen_q     <= flen_d;
            k_q        <= k_d;
            fhi_q      <= fhi_d;
            tlen_q     <= tlen_d;
            j_q        <= j_d;
            hold_q     <= hold_d;
            tbl_addr   <= tbl_addr_d;
            mem_addr   <= mem_addr_d;
            mem_do     <= mem_do_d;
            mem_we     <= mem_we_d;
            reg_addr   <= reg_addr_d;
            reg_do     <= reg_do_d;
            reg_cs     <= reg_cs_d;
            reg_we     <= reg_cs_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_bus_init_sequencer.sv
// Scoreboard bench for bus_init_sequencer: expected writes are queued at start and
// popped as strobes rise; timing, abort and async reset are checked directly.
module tb_bus_init_sequencer;

    localparam int HOLD = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [13:0] fill_base = '0;
    logic [13:0] fill_len = '0;
    logic [3:0]  fill_hi = '0;
    logic [6:0]  tbl_len = '0;
    logic [5:0]  tbl_addr;
    logic [13:0] tbl_data = '0;
    logic [13:0] mem_addr;
    logic [11:0] mem_do;
    logic        mem_we;
    logic [5:0]  reg_addr;
    logic [7:0]  reg_do;
    logic        reg_cs;
    logic        reg_we;
    logic        busy;
    logic        done;

    bus_init_sequencer #(
        .ADDR_WIDTH(14), .DATA_WIDTH(12), .REG_AW(6), .TABLE_DEPTH(64), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .fill_base(fill_base), .fill_len(fill_len), .fill_hi(fill_hi), .tbl_len(tbl_len),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data), .mem_addr(mem_addr), .mem_do(mem_do),
        .mem_we(mem_we), .reg_addr(reg_addr), .reg_do(reg_do), .reg_cs(reg_cs),
        .reg_we(reg_we), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [13:0] rom [64];
    always @(posedge clk) tbl_data <= rom[tbl_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    logic [25:0] mem_q [$];
    logic [13:0] reg_q [$];

    int first_mem_rise = -1, last_mem_rise = -1, last_mem_fall = -1;
    int first_reg_rise = -1, last_reg_rise = -1;
    int n_mem_rise = 0, n_reg_rise = 0, done_count = 0, exp_done = 0;
    int we_width = 0, cs_width = 0;
    bit expect_short = 1'b0;
    logic prev_we = 1'b0, prev_cs = 1'b0;
    logic [13:0] cap_addr = '0;
    int start_cyc = 0, done_cyc = 0;

    // Strobe monitor: pops the scoreboard on each rising strobe, checks hold and spacing
    always @(negedge clk) begin
        logic [25:0] me;
        logic [13:0] re;
        if (mem_we || reg_cs) check_eq("strobe_overlap", 32'(mem_we && reg_cs), 32'd0);
        if (reg_cs || reg_we) check_eq("reg_we_eq_cs", 32'(reg_we), 32'(reg_cs));
        if (mem_we && !prev_we) begin
            n_mem_rise++;
            cap_addr = mem_addr;
            we_width = 0;
            if (mem_q.size() == 0) check_eq("mem_write_expected", 32'd0, 32'd1);
            else begin
                me = mem_q.pop_front();
                check_eq("mem_addr", 32'(mem_addr), 32'(me[25:12]));
                check_eq("mem_data", 32'(mem_do), 32'(me[11:0]));
            end
            if (last_mem_rise >= 0) check_eq("mem_spacing", 32'(cyc - last_mem_rise), HOLD + 1);
            if (first_mem_rise < 0) first_mem_rise = cyc;
            last_mem_rise = cyc;
        end else if (mem_we) begin
            check_eq("mem_addr_stable", 32'(mem_addr), 32'(cap_addr));
        end
        if (mem_we) we_width++;
        if (!mem_we && prev_we) begin
            last_mem_fall = cyc;
            if (!expect_short) check_eq("mem_hold", 32'(we_width), HOLD);
        end
        if (reg_cs && !prev_cs) begin
            n_reg_rise++;
            cs_width = 0;
            if (reg_q.size() == 0) check_eq("reg_write_expected", 32'd0, 32'd1);
            else begin
                re = reg_q.pop_front();
                check_eq("reg_addr", 32'(reg_addr), 32'(re[13:8]));
                check_eq("reg_data", 32'(reg_do), 32'(re[7:0]));
            end
            if (last_reg_rise >= 0) check_eq("reg_spacing", 32'(cyc - last_reg_rise), HOLD + 2);
            if (first_reg_rise < 0) first_reg_rise = cyc;
            last_reg_rise = cyc;
        end
        if (reg_cs) cs_width++;
        if (!reg_cs && prev_cs && !expect_short) check_eq("reg_hold", 32'(cs_width), HOLD);
        if (done) done_count++;
        prev_we = mem_we;
        prev_cs = reg_cs;
    end

    // Queue the writes the sequence should produce, then pulse start for one edge
    task automatic launch(input logic [1:0] m, input logic [13:0] base, input logic [13:0] len,
                          input logic [3:0] hi, input logic [6:0] tl);
        int ntl;
        if (m == 2'b01 || m == 2'b10) begin
            for (int k = 0; k < int'(len); k++) begin
                logic [13:0] a;
                logic [7:0]  lo;
                a  = base + 14'(k);
                lo = 8'(k);
                mem_q.push_back({a, hi, lo});
            end
        end
        if (m != 2'b01) begin
            ntl = (int'(tl) > 64) ? 64 : int'(tl);
            for (int j = 0; j < ntl; j++) reg_q.push_back(rom[j]);
        end
        first_mem_rise = -1; last_mem_rise = -1; last_mem_fall = -1;
        first_reg_rise = -1; last_reg_rise = -1;
        mode = m; fill_base = base; fill_len = len; fill_hi = hi; tbl_len = tl;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic run_seq(input logic [1:0] m, input logic [13:0] base, input logic [13:0] len,
                           input logic [3:0] hi, input logic [6:0] tl, input bit poke);
        bit got;
        bit busy_exp;
        launch(m, base, len, hi, tl);
        busy_exp = (mem_q.size() + reg_q.size()) != 0;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (i == 0 && busy_exp) check_eq("busy_running", 32'(busy), 32'd1);
            if (poke && i == 4) begin
                start = 1'b1; mode = 2'b00; fill_base = ~fill_base; fill_hi = ~fill_hi;
                fill_len = 14'd1; tbl_len = 7'd5;
            end
            if (poke && i == 5) start = 1'b0;
            if (done) begin
                got = 1'b1;
                done_cyc = cyc;
                check_eq("busy_at_done", 32'(busy), 32'd0);
            end
        end
        start = 1'b0;
        check_eq("done_seen", 32'(got), 32'd1);
        exp_done++;
        check_eq("mem_q_drained", 32'(mem_q.size()), 32'd0);
        check_eq("reg_q_drained", 32'(reg_q.size()), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        bit d;
        int r0;
        for (int i = 0; i < 64; i++) rom[i] = 14'($urandom);
        rom[0] = {6'h18, 8'h04};
        rom[1] = {6'h11, 8'h18};
        rom[2] = {6'h20, 8'h0c};

        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_reg_cs", 32'(reg_cs), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_tbl_addr", 32'(tbl_addr), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic fill with a start pulse and input changes while busy
        run_seq(2'b01, 14'h0000, 14'd4, 4'h1, 7'd0, 1'b1);
        check_eq("fill_latency", 32'(first_mem_rise - start_cyc), 32'd1);
        check_eq("fill_done_lat", 32'(done_cyc - first_mem_rise), 32'd36);

        // Table, started in the cycle done is high
        run_seq(2'b00, 14'h0000, 14'd0, 4'h0, 7'd3, 1'b0);
        check_eq("tbl_latency", 32'(first_reg_rise - start_cyc), 32'd2);

        run_seq(2'b10, 14'h0040, 14'd2, 4'h7, 7'd1, 1'b0);
        check_eq("fill_before_tbl",
                 32'((last_mem_fall >= 0) && (first_reg_rise > last_mem_fall)), 32'd1);

        run_seq(2'b01, 14'h3FFE, 14'd4, 4'hF, 7'd0, 1'b0);

        r0 = n_mem_rise + n_reg_rise;
        run_seq(2'b10, 14'h0123, 14'd0, 4'h3, 7'd0, 1'b0);
        check_eq("zero_len_done_lat", 32'(done_cyc - start_cyc), 32'd1);
        check_eq("zero_len_no_strobe", 32'(n_mem_rise + n_reg_rise - r0), 32'd0);

        run_seq(2'b11, 14'h0000, 14'd9, 4'h0, 7'd2, 1'b0);

        // Oversized table length clamps to the full table
        r0 = n_reg_rise;
        run_seq(2'b00, 14'h0000, 14'd0, 4'h0, 7'd100, 1'b0);
        check_eq("tbl_clamp_count", 32'(n_reg_rise - r0), 32'd64);
        repeat (3) @(negedge clk);

        // Abort on the third cycle of a table write
        launch(2'b00, 14'h0000, 14'd0, 4'h0, 7'd3);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (reg_cs) got = 1'b1;
        end
        check_eq("abort_write_seen", 32'(got), 32'd1);
        @(negedge clk);
        @(negedge clk);
        expect_short = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_reg_cs", 32'(reg_cs), 32'd0);
        check_eq("abort_reg_we", 32'(reg_we), 32'd0);
        check_eq("abort_mem_we", 32'(mem_we), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        abort = 1'b0;
        d = 1'b0;
        r0 = n_reg_rise + n_mem_rise;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            d |= done;
        end
        check_eq("abort_no_done", 32'(d), 32'd0);
        check_eq("abort_no_more_writes", 32'(n_reg_rise + n_mem_rise - r0), 32'd0);
        mem_q.delete();
        reg_q.delete();
        expect_short = 1'b0;

        // Asynchronous reset in the middle of a fill write
        launch(2'b01, 14'h0100, 14'd6, 4'h5, 7'd0);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (mem_we) got = 1'b1;
        end
        check_eq("rst_fill_seen", 32'(got), 32'd1);
        @(negedge clk);
        @(negedge clk);
        expect_short = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_mem_we", 32'(mem_we), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("arst_mem_do", 32'(mem_do), 32'd0);
        check_eq("arst_reg_cs", 32'(reg_cs), 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mem_q.delete();
        reg_q.delete();
        @(negedge clk);
        expect_short = 1'b0;
        run_seq(2'b01, 14'h0020, 14'd3, 4'hA, 7'd0, 1'b0);
        check_eq("post_rst_latency", 32'(first_mem_rise - start_cyc), 32'd1);

        repeat (5) @(negedge clk);
        check_eq("done_count", 32'(done_count), 32'(exp_done));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
